// File: rtl/controle_pkg.sv
// Shared types and constants for the code-lock access controller.
package controle_pkg;
  typedef enum logic [2:0] {
    LIMPA, ESPERA, ENVIA, AGUARDA, FALHA, BLOQUEADO, LIBERADO
  } estado_t;

  localparam int TAM_CODIGO  = 6;
  localparam int MAX_DIGITOS = TAM_CODIGO + 1;
  localparam int DIGITO_W    = 4;

  function automatic int largura(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector; the pulse appears three clocks after the raw edge.
module sincroniza_borda (
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic pulso
);
  logic [2:0] sinc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sinc  <= '0;
      pulso <= 1'b0;
    end else begin
      sinc  <= {sinc[1:0], entrada};
      pulso <= sinc[1] & ~sinc[2];
    end
  end
endmodule

// File: rtl/controle_acesso.sv
// Sequencing controller for the code lock: conditions the button, strobes
// digits into the lock, counts failed attempts and enforces a timed lockout.
module controle_acesso
  import controle_pkg::*;
#(
  parameter int MAX_TENTATIVAS  = 3,
  parameter int BLOQUEIO_CICLOS = 1000,
  parameter int TIMEOUT_CICLOS  = 500,
  parameter int LAT_TRAVA       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                insere,
  input  logic [DIGITO_W-1:0] numero,
  input  logic                lock_aberto,
  input  logic                lock_falha,
  output logic                lock_reset,
  output logic [DIGITO_W-1:0] digito,
  output logic                digito_valido,
  output logic                liberado,
  output logic                bloqueado,
  output logic [1:0]          tentativas_rest
);
  localparam int BLQ_W = largura(BLOQUEIO_CICLOS);
  localparam int TMO_W = largura(TIMEOUT_CICLOS);
  localparam int LAT_W = largura(LAT_TRAVA);
  localparam int CNT_W = largura(MAX_DIGITOS);

  localparam logic [BLQ_W-1:0] BLQ_FIM  = BLQ_W'(BLOQUEIO_CICLOS - 1);
  localparam logic [TMO_W-1:0] TMO_FIM  = TMO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [LAT_W-1:0] LAT_FIM  = LAT_W'(LAT_TRAVA - 1);
  localparam logic [CNT_W-1:0] DIG_MAX  = CNT_W'(MAX_DIGITOS);
  localparam logic [1:0]       TENT_MAX = 2'(MAX_TENTATIVAS);

  estado_t          estado, prox;
  logic             ev;
  logic [CNT_W-1:0] dig_cnt;
  logic [TMO_W-1:0] idle_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [BLQ_W-1:0] blq_cnt;

  sincroniza_borda u_botao (
    .clk    (clk),
    .reset  (reset),
    .entrada(insere),
    .pulso  (ev)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= LIMPA;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      LIMPA:   prox = ESPERA;
      ESPERA: begin
        if (ev) prox = ENVIA;
        else if (dig_cnt != '0 && idle_cnt == TMO_FIM) prox = FALHA;
      end
      ENVIA:   prox = AGUARDA;
      // lock result is sampled in the last latency cycle; failure wins
      AGUARDA: begin
        if (lat_cnt == LAT_FIM) begin
          if (lock_falha)              prox = FALHA;
          else if (lock_aberto)        prox = LIBERADO;
          else if (dig_cnt == DIG_MAX) prox = FALHA;
          else                         prox = ESPERA;
        end
      end
      FALHA:     prox = (tentativas_rest <= 2'd1) ? BLOQUEADO : LIMPA;
      BLOQUEADO: if (blq_cnt == BLQ_FIM) prox = LIMPA;
      LIBERADO:  if (ev) prox = LIMPA;
      default:   prox = LIMPA;
    endcase
  end

  always_comb begin
    lock_reset    = (estado == LIMPA) || (estado == BLOQUEADO);
    digito_valido = (estado == ENVIA);
    liberado      = (estado == LIBERADO);
    bloqueado     = (estado == BLOQUEADO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digito          <= '0;
      dig_cnt         <= '0;
      idle_cnt        <= '0;
      lat_cnt         <= '0;
      blq_cnt         <= '0;
      tentativas_rest <= TENT_MAX;
    end else begin
      if (estado == ESPERA && ev) digito <= numero;

      if (estado == LIMPA)      dig_cnt <= '0;
      else if (estado == ENVIA) dig_cnt <= dig_cnt + 1'b1;

      // idle timer only runs once an entry has started and restarts per digit
      idle_cnt <= (estado == ESPERA && dig_cnt != '0 && !ev) ? idle_cnt + 1'b1 : '0;
      lat_cnt  <= (estado == AGUARDA) ? lat_cnt + 1'b1 : '0;
      blq_cnt  <= (estado == BLOQUEADO) ? blq_cnt + 1'b1 : '0;

      if (estado == FALHA && tentativas_rest != 2'd0)
        tentativas_rest <= tentativas_rest - 2'd1;
      else if ((estado == BLOQUEADO && blq_cnt == BLQ_FIM) ||
               (estado == AGUARDA && prox == LIBERADO))
        tentativas_rest <= TENT_MAX;
    end
  end
endmodule

// File: tb/tb_controle_acesso.sv
// Directed bench for controle_acesso: a procedural timeline model predicts
// every output each cycle; a simple lock stub answers the digit strobes.
module tb_controle_acesso;
  localparam int MAX_T = 3;
  localparam int BLOQ  = 1000;
  localparam int TMO   = 500;
  localparam int LAT   = 2;
  localparam int MAXD  = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       insere;
  logic [3:0] numero;
  logic       lock_aberto = 1'b0;
  logic       lock_falha  = 1'b0;
  logic       lock_reset, digito_valido, liberado, bloqueado;
  logic [3:0] digito;
  logic [1:0] tentativas_rest;

  always #5 clk = ~clk;

  controle_acesso #(
    .MAX_TENTATIVAS (MAX_T),
    .BLOQUEIO_CICLOS(BLOQ),
    .TIMEOUT_CICLOS (TMO),
    .LAT_TRAVA      (LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .insere         (insere),
    .numero         (numero),
    .lock_aberto    (lock_aberto),
    .lock_falha     (lock_falha),
    .lock_reset     (lock_reset),
    .digito         (digito),
    .digito_valido  (digito_valido),
    .liberado       (liberado),
    .bloqueado      (bloqueado),
    .tentativas_rest(tentativas_rest)
  );

  // lock stub: opens / fails once enough digits have been strobed in
  int         open_at = 99, fail_at = 99;
  int         lk_cnt = 0, vcount = 0;
  logic [3:0] got_q[$];

  always @(negedge clk) begin
    if (reset !== 1'b1 || lock_reset) lk_cnt = 0;
    else if (digito_valido) begin
      lk_cnt++;
      vcount++;
      got_q.push_back(digito);
    end
    lock_aberto = (lk_cnt >= open_at);
    lock_falha  = (lk_cnt >= fail_at);
  end

  // timeline model
  logic       exp_lr, exp_vld, exp_lib, exp_blq;
  logic [3:0] exp_dig, m_dig;
  logic [1:0] exp_tent;
  int         m_tent;
  logic [3:0] hist;
  logic       ev_cur, s_ev, s_ab, s_fa, aborted;
  logic [3:0] s_num;

  task automatic set_exp(input bit lr, input bit vld, input bit lib, input bit blq);
    exp_lr = lr; exp_vld = vld; exp_lib = lib; exp_blq = blq;
    exp_dig = m_dig; exp_tent = 2'(m_tent);
  endtask

  task automatic set_reset_exp();
    m_dig = 4'd0; m_tent = MAX_T;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset !== 1'b1) begin aborted = 1'b1; return; end
    s_ev = ev_cur; s_num = numero; s_ab = lock_aberto; s_fa = lock_falha;
    hist = {hist[2:0], insere};
    ev_cur = hist[2] & ~hist[3];
  endtask

  task automatic run_model();
    int nd, idle, fim;
    forever begin
      set_exp(1'b1, 1'b0, 1'b0, 1'b0); tick(); if (aborted) return;
      nd = 0; idle = 0; fim = 0;
      while (fim == 0) begin
        set_exp(1'b0, 1'b0, 1'b0, 1'b0); tick(); if (aborted) return;
        if (s_ev) begin
          m_dig = s_num;
          set_exp(1'b0, 1'b1, 1'b0, 1'b0); tick(); if (aborted) return;
          nd++;
          for (int w = 0; w < LAT; w++) begin
            set_exp(1'b0, 1'b0, 1'b0, 1'b0); tick(); if (aborted) return;
          end
          if (s_fa)           fim = 1;
          else if (s_ab)      fim = 2;
          else if (nd >= MAXD) fim = 1;
          else                idle = 0;
        end else if (nd > 0) begin
          idle++;
          if (idle == TMO) fim = 1;
        end
      end
      if (fim == 2) begin
        m_tent = MAX_T;
        forever begin
          set_exp(1'b0, 1'b0, 1'b1, 1'b0); tick(); if (aborted) return;
          if (s_ev) break;
        end
      end else begin
        set_exp(1'b0, 1'b0, 1'b0, 1'b0); tick(); if (aborted) return;
        if (m_tent > 0) m_tent--;
        if (m_tent == 0) begin
          for (int b = 0; b < BLOQ; b++) begin
            set_exp(1'b1, 1'b0, 1'b0, 1'b1); tick(); if (aborted) return;
          end
          m_tent = MAX_T;
        end
      end
    end
  endtask

  initial begin
    set_reset_exp();
    forever begin
      wait (reset === 1'b1);
      aborted = 1'b0; hist = 4'd0; ev_cur = 1'b0;
      set_reset_exp();
      run_model();
      set_reset_exp();
      wait (reset !== 1'b1);
    end
  end

  // checking
  int n_chk = 0, n_fail = 0, blq_cnt = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (bloqueado === 1'b1) blq_cnt++;
    if (reset === 1'b1) begin
      n_chk++;
      if ({lock_reset, digito, digito_valido, liberado, bloqueado, tentativas_rest} !==
          {exp_lr, exp_dig, exp_vld, exp_lib, exp_blq, exp_tent}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL per_cycle t=%0t: got lr=%b dig=%0d vld=%b lib=%b blq=%b tent=%0d, required lr=%b dig=%0d vld=%b lib=%b blq=%b tent=%0d",
                   $time, lock_reset, digito, digito_valido, liberado, bloqueado, tentativas_rest,
                   exp_lr, exp_dig, exp_vld, exp_lib, exp_blq, exp_tent);
      end
    end
  endtask

  task automatic press(input int d);
    cyc();
    numero = 4'(d); insere = 1'b1;
    repeat (4) cyc();
    insere = 1'b0;
    repeat (6) cyc();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_lock_reset"}, int'(lock_reset), 1);
    chk({nm, "_digito"}, int'(digito), 0);
    chk({nm, "_valido"}, int'(digito_valido), 0);
    chk({nm, "_liberado"}, int'(liberado), 0);
    chk({nm, "_bloqueado"}, int'(bloqueado), 0);
    chk({nm, "_tent"}, int'(tentativas_rest), 3);
  endtask

  int seq1[6] = '{5, 9, 0, 9, 8, 1};
  int seq2[7] = '{5, 3, 9, 0, 9, 8, 1};

  initial begin
    int base, n, waited;
    bit found;
    reset = 1'b1; insere = 1'b0; numero = 4'd0;
    #1 reset = 1'b0;
    repeat (3) cyc();
    chk_reset_vals("por");
    #2 reset = 1'b1;
    repeat (2) cyc();

    // six-digit code, lock opens on the sixth
    open_at = 6; fail_at = 99;
    base = got_q.size();
    foreach (seq1[i]) press(seq1[i]);
    repeat (2) cyc();
    chk("code6_liberado", int'(liberado), 1);
    chk("code6_tent", int'(tentativas_rest), 3);
    chk("code6_count", got_q.size() - base, 6);
    foreach (seq1[i]) chk($sformatf("code6_dig%0d", i), int'(got_q[base + i]), seq1[i]);
    n = vcount;
    press(4);
    chk("relock_liberado", int'(liberado), 0);
    chk("relock_discard", vcount - n, 0);

    // one tolerated wrong digit, lock opens on the seventh
    open_at = 7;
    base = got_q.size();
    foreach (seq2[i]) press(seq2[i]);
    repeat (2) cyc();
    chk("code7_liberado", int'(liberado), 1);
    chk("code7_count", got_q.size() - base, 7);
    chk("code7_last", int'(got_q[base + 6]), 1);
    press(0);

    // three failed attempts lead to lockout
    open_at = 99; fail_at = 2; blq_cnt = 0;
    for (int a = 0; a < 3; a++) begin
      press(1); press(2);
      repeat (3) cyc();
      chk($sformatf("fail%0d_tent", a), int'(tentativas_rest), 2 - a);
    end
    chk("lockout_bloqueado", int'(bloqueado), 1);
    n = vcount;
    press(5); press(6);
    chk("lockout_ignores_ev", vcount - n, 0);
    found = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      if (!bloqueado) begin found = 1'b1; break; end
    end
    chk("lockout_ends", int'(found), 1);
    chk("lockout_len", blq_cnt, 1000);
    chk("lockout_tent_restored", int'(tentativas_rest), 3);
    chk("lockout_limpa_reset", int'(lock_reset), 1);
    cyc();
    chk("lockout_reset_1cycle", int'(lock_reset), 0);

    // edges during ENVIA/AGUARDA are dropped; a held button is one event
    fail_at = 99;
    n = vcount;
    cyc(); numero = 4'd7; insere = 1'b1;
    cyc(); insere = 1'b0;
    cyc(); insere = 1'b1;
    cyc(); insere = 1'b0;
    repeat (8) cyc();
    chk("double_pulse_one_digit", vcount - n, 1);
    n = vcount;
    numero = 4'd3; insere = 1'b1;
    repeat (20) cyc();
    insere = 1'b0;
    repeat (6) cyc();
    chk("held_one_digit", vcount - n, 1);

    // idle timeout after digits have been entered
    found = 1'b0; waited = 0;
    for (int i = 0; i < 700; i++) begin
      cyc(); waited++;
      if (tentativas_rest != 2'd3) begin found = 1'b1; break; end
    end
    chk("timeout_hit", int'(found), 1);
    chk("timeout_tent", int'(tentativas_rest), 2);
    chk("timeout_lock_reset", int'(lock_reset), 1);

    // reset in the middle of AGUARDA
    cyc(); numero = 4'd6; insere = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (digito_valido) begin found = 1'b1; break; end
    end
    insere = 1'b0;
    chk("aguarda_strobe_seen", int'(found), 1);
    @(posedge clk); #2 reset = 1'b0;
    #1 chk_reset_vals("rst_aguarda");
    repeat (2) cyc();
    #2 reset = 1'b1;
    #1 chk("rel1_limpa", int'(lock_reset), 1);
    chk("rel1_tent", int'(tentativas_rest), 3);
    @(posedge clk); #1 chk("rel1_espera", int'(lock_reset), 0);

    // reset in the middle of BLOQUEADO
    fail_at = 2;
    for (int a = 0; a < 3; a++) begin press(1); press(2); repeat (3) cyc(); end
    repeat (300) cyc();
    chk("mid_lockout_bloqueado", int'(bloqueado), 1);
    @(posedge clk); #2 reset = 1'b0;
    #1 chk_reset_vals("rst_bloq");
    repeat (2) cyc();
    #2 reset = 1'b1;
    #1 chk("rel2_limpa", int'(lock_reset), 1);
    chk("rel2_tent", int'(tentativas_rest), 3);
    repeat (5) cyc();
    chk("rel2_no_lockout", int'(bloqueado), 0);

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
